// File: rtl/capture_pkg.sv
// Shared types for the capture path: FSM state encoding and the FIFO entry layout.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } capture_state_e;

  // Entry layout at the default 12-bit sample width; the top rebuilds it for its own DATA_WIDTH.
  localparam int unsigned CAP_DATA_WIDTH = 12;

  typedef struct packed {
    logic                      last;
    logic [CAP_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_areset_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/capture_batcher.sv
// Groups ADC or ramp samples into fixed-size batches, buffers them and streams them out
// with the final sample of each complete batch tagged.
module capture_batcher
  import capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned BATCH_SIZE = 1024,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MOCK_DIV   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_capture_enable,
  input  logic                  i_mock_enable,
  input  logic                  i_reset_fifo,
  input  logic [DATA_WIDTH-1:0] i_adc_data,
  input  logic                  i_adc_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_fifo_overflow,
  output logic                  o_batch_ready,
  output logic                  o_busy,
  output capture_state_e        o_state
);

  localparam int unsigned CNT_W = $clog2(BATCH_SIZE);
  localparam int unsigned DIV_W = (MOCK_DIV > 1) ? $clog2(MOCK_DIV) : 1;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH_SIZE - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOCK_DIV - 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  capture_state_e        state_q;
  logic                  src_mock_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIV_W-1:0]      div_q;
  logic [DATA_WIDTH-1:0] ramp_q;
  logic                  ovf_q;
  logic                  br_q;

  entry_t                push_entry;
  entry_t                head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic                  mock_tick;
  logic                  src_event;
  logic                  in_capture;
  logic                  pop;
  logic                  can_push;
  logic                  push;
  logic                  is_last;

  assign mock_tick  = src_mock_q && (div_q == DIV_LAST);
  assign src_event  = src_mock_q ? mock_tick : i_adc_valid;
  assign in_capture = (state_q == CAPTURE);
  assign pop        = !fifo_empty && i_ready;
  // Fullness is judged after this cycle's pop, so a full FIFO being drained still accepts.
  assign can_push   = !fifo_full || pop;
  assign push       = in_capture && i_capture_enable && src_event && can_push && !i_reset_fifo;
  assign is_last    = (cnt_q == LAST_IDX);

  assign push_entry.last = is_last;
  assign push_entry.data = src_mock_q ? ramp_q : i_adc_data;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .flush_i    (i_reset_fifo),
    .push_i     (push),
    .wdata_i    (push_entry),
    .pop_i      (pop),
    .rdata_o    (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= IDLE;
      src_mock_q <= 1'b0;
      cnt_q      <= '0;
      div_q      <= '0;
      ramp_q     <= '0;
      ovf_q      <= 1'b0;
      br_q       <= 1'b0;
    end else if (i_reset_fifo) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      ramp_q  <= '0;
      ovf_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      // Any accepted beat after a last beat starts the next batch, so one rule covers set and clear.
      if (pop) br_q <= head.last;
      if (in_capture && src_mock_q) begin
        div_q <= mock_tick ? '0 : div_q + 1'b1;
        if (mock_tick) ramp_q <= ramp_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_capture_enable) begin
            state_q    <= CAPTURE;
            src_mock_q <= i_mock_enable;
            cnt_q      <= '0;
          end
        end
        CAPTURE: begin
          if (!i_capture_enable) begin
            state_q <= DRAIN;
          end else if (src_event) begin
            if (can_push) begin
              cnt_q <= cnt_q + 1'b1;
              if (is_last) state_q <= DRAIN;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            if (i_capture_enable) begin
              state_q    <= CAPTURE;
              src_mock_q <= i_mock_enable;
              cnt_q      <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid         = !fifo_empty;
  assign o_data          = o_valid ? head.data : '0;
  assign o_last          = o_valid && head.last;
  assign o_fifo_overflow = ovf_q;
  assign o_batch_ready   = br_q;
  assign o_busy          = (state_q != IDLE);
  assign o_state         = state_q;

endmodule

// File: tb/tb_capture_batcher.sv
// Bench for capture_batcher: directed scenarios with randomized ready/ADC stimulus, checked
// every cycle against a queue-based reference model of the batching rules.
module tb_capture_batcher;

  localparam int DW = 12;
  localparam int BS = 8;
  localparam int FD = 4;
  localparam int MD = 1;

  // clock / reset
  logic clk = 1'b0;
  logic areset_n;
  always #5 clk = ~clk;

  logic          cap, mock, rstf, adc_v, rdy;
  logic [DW-1:0] adc_d;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last, o_ovf, o_br, o_busy;
  capture_pkg::capture_state_e dut_state;

  capture_batcher #(
    .DATA_WIDTH (DW),
    .BATCH_SIZE (BS),
    .FIFO_DEPTH (FD),
    .MOCK_DIV   (MD)
  ) dut (
    .i_clk            (clk),
    .i_areset_n       (areset_n),
    .i_capture_enable (cap),
    .i_mock_enable    (mock),
    .i_reset_fifo     (rstf),
    .i_adc_data       (adc_d),
    .i_adc_valid      (adc_v),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .o_last           (o_last),
    .i_ready          (rdy),
    .o_fifo_overflow  (o_ovf),
    .o_batch_ready    (o_br),
    .o_busy           (o_busy),
    .o_state          (dut_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: the buffered stream is a queue of {last, data}
  logic [DW:0] exp_q[$];
  int m_mode = 0;   // 0 idle, 1 capturing, 2 draining
  bit m_src = 0;
  int m_cnt = 0, m_div = 0, m_ramp = 0;
  bit m_ovf = 0, m_br = 0;

  task automatic model_edge();
    int pre;
    bit ev;
    logic [DW-1:0] smp;
    if (rstf) begin
      exp_q.delete();
      m_mode = 0; m_cnt = 0; m_div = 0; m_ramp = 0; m_ovf = 0; m_br = 0;
      return;
    end
    pre = exp_q.size();
    if (pre > 0 && rdy) begin
      m_br = exp_q[0][DW];
      exp_q.delete(0);
    end
    case (m_mode)
      0: if (cap) begin m_mode = 1; m_src = mock; m_cnt = 0; end
      1: begin
        ev  = m_src ? (m_div == MD - 1) : adc_v;
        smp = m_src ? m_ramp[DW-1:0] : adc_d;
        if (m_src) begin
          if (ev) begin m_div = 0; m_ramp = (m_ramp + 1) % (1 << DW); end
          else m_div++;
        end
        if (!cap) m_mode = 2;
        else if (ev) begin
          if (exp_q.size() < FD) begin
            exp_q.push_back({(m_cnt == BS - 1), smp});
            if (m_cnt == BS - 1) m_mode = 2;
            m_cnt++;
          end else m_ovf = 1;
        end
      end
      default: if (pre == 0) begin
        if (cap) begin m_mode = 1; m_src = mock; m_cnt = 0; end
        else m_mode = 0;
      end
    endcase
  endtask

  function automatic logic [DW+4:0] model_view();
    logic v;
    v = (exp_q.size() != 0);
    return {v, (v ? exp_q[0] : {(DW+1){1'b0}}), m_ovf, m_br, (m_mode != 0)};
  endfunction

  function automatic logic [DW+4:0] dut_view();
    return {o_valid, o_last, o_data, o_ovf, o_br, o_busy};
  endfunction

  // driver: inputs change at negedge; the model advances over the coming posedge
  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset_data got=%h want=0", o_data); end
    n_vec++; if (o_last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b want=0", o_last); end
    n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", o_ovf); end
    n_vec++; if (o_br !== 1'b0) begin n_err++; $display("FAIL reset_br got=%b want=0", o_br); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_nominal_mock();
    logic [DW:0] beats[$];
    logic [DW:0] e;
    bit got_last;
    bit done;
    rstf = 1; step(); rstf = 0;
    mock = 1; cap = 1; rdy = 1;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      got_last = 0;
      if (o_valid && rdy) begin beats.push_back({o_last, o_data}); got_last = o_last; end
      if (beats.size() == BS) cap = 0;
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL nominal_cycle dut=%h model=%h", dut_view(), model_view()); end
      if (got_last) begin
        n_vec++;
        if (o_br !== 1'b1) begin n_err++; $display("FAIL nominal_br_rise got=%b want=1", o_br); end
      end
      done = (m_mode == 0 && exp_q.size() == 0 && beats.size() >= BS);
    end
    n_vec++;
    if (beats.size() != BS) begin n_err++; $display("FAIL nominal_count got=%0d want=%0d", beats.size(), BS); end
    for (int i = 0; i < beats.size() && i < BS; i++) begin
      e = {(i == BS - 1), DW'(i)};
      n_vec++;
      if (beats[i] !== e) begin n_err++; $display("FAIL nominal_beat%0d got=%h want=%h", i, beats[i], e); end
    end
    n_vec++;
    if (o_ovf !== 1'b0) begin n_err++; $display("FAIL nominal_ovf got=%b want=0", o_ovf); end
  endtask

  task automatic test_overflow();
    logic [DW:0] beats[$];
    logic [DW:0] e;
    bit done;
    mock = 0; cap = 1; rdy = 0; adc_v = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      adc_v = 1; adc_d = DW'(12'hA0 + i);
      step();
      n_vec++;
      if (o_ovf !== (i >= 4)) begin n_err++; $display("FAIL ovf_flag_s%0d got=%b want=%b", i, o_ovf, (i >= 4)); end
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL ovf_cycle dut=%h model=%h", dut_view(), model_view()); end
    end
    adc_v = 0; cap = 0;
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      rdy = 1'($urandom_range(0, 1));
      if (o_valid && rdy) beats.push_back({o_last, o_data});
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL ovf_drain dut=%h model=%h", dut_view(), model_view()); end
      done = (m_mode == 0 && exp_q.size() == 0);
    end
    n_vec++;
    if (beats.size() != 4) begin n_err++; $display("FAIL ovf_count got=%0d want=4", beats.size()); end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      e = {1'b0, DW'(12'hA0 + i)};
      n_vec++;
      if (beats[i] !== e) begin n_err++; $display("FAIL ovf_beat%0d got=%h want=%h", i, beats[i], e); end
    end
    n_vec++;
    if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b want=1", o_ovf); end
  endtask

  task automatic test_flush();
    bit first;
    bit done;
    mock = 0; cap = 1; rdy = 0; adc_v = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      adc_v = 1; adc_d = DW'($urandom);
      step();
    end
    adc_v = 0; rstf = 1;
    step();
    rstf = 0;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b want=0", o_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b want=0", o_busy); end
    n_vec++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL flush_ovf got=%b want=0", o_ovf); end
    n_vec++; if (o_br !== 1'b0) begin n_err++; $display("FAIL flush_br got=%b want=0", o_br); end
    mock = 1;
    first = 1; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      rdy = 1'($urandom_range(0, 1));
      if (m_mode == 2) cap = 0;
      if (o_valid && rdy && first) begin
        first = 0;
        n_vec++;
        if (o_data !== '0) begin n_err++; $display("FAIL flush_ramp_restart got=%h want=0", o_data); end
      end
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL flush_cycle dut=%h model=%h", dut_view(), model_view()); end
      done = (m_mode == 0 && exp_q.size() == 0 && !cap);
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL flush_timeout got=busy want=idle"); end
  endtask

  task automatic test_abort();
    logic [DW:0] beats[$];
    logic [DW:0] e;
    bit done;
    rstf = 1; step(); rstf = 0;
    mock = 1; cap = 1; rdy = 0;
    step();
    repeat (3) step();
    cap = 0;
    step();
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      rdy = 1'($urandom_range(0, 1));
      if (o_valid && rdy) beats.push_back({o_last, o_data});
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL abort_cycle dut=%h model=%h", dut_view(), model_view()); end
      done = (m_mode == 0 && exp_q.size() == 0);
    end
    n_vec++;
    if (beats.size() != 3) begin n_err++; $display("FAIL abort_count got=%0d want=3", beats.size()); end
    for (int i = 0; i < beats.size() && i < 3; i++) begin
      e = {1'b0, DW'(i)};
      n_vec++;
      if (beats[i] !== e) begin n_err++; $display("FAIL abort_beat%0d got=%h want=%h", i, beats[i], e); end
    end
    n_vec++; if (o_br !== 1'b0) begin n_err++; $display("FAIL abort_br got=%b want=0", o_br); end
    n_vec++;
    if (dut_state !== capture_pkg::IDLE) begin n_err++; $display("FAIL abort_state got=%0d want=0", dut_state); end
  endtask

  task automatic test_back_to_back();
    logic [DW:0] beats[$];
    logic [DW:0] e;
    logic [DW:0] beat;
    bit acc;
    bit done;
    rstf = 1; step(); rstf = 0;
    mock = 1; cap = 1; rdy = 1;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      acc = o_valid && rdy;
      beat = {o_last, o_data};
      if (acc) begin
        beats.push_back(beat);
        if (beat[DW-1:0] == DW'(BS)) begin
          n_vec++;
          if (o_br !== 1'b1) begin n_err++; $display("FAIL b2b_br_before8 got=%b want=1", o_br); end
        end
      end
      if (beats.size() == 2 * BS) cap = 0;
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL b2b_cycle dut=%h model=%h", dut_view(), model_view()); end
      if (acc && beat[DW-1:0] == DW'(BS)) begin
        n_vec++;
        if (o_br !== 1'b0) begin n_err++; $display("FAIL b2b_br_clear got=%b want=0", o_br); end
      end
      if (acc && beat[DW]) begin
        n_vec++;
        if (o_br !== 1'b1) begin n_err++; $display("FAIL b2b_br_set got=%b want=1", o_br); end
      end
      done = (m_mode == 0 && exp_q.size() == 0 && beats.size() >= 2 * BS);
    end
    n_vec++;
    if (beats.size() != 2 * BS) begin n_err++; $display("FAIL b2b_count got=%0d want=%0d", beats.size(), 2 * BS); end
    for (int i = 0; i < beats.size() && i < 2 * BS; i++) begin
      e = {(i == BS - 1 || i == 2 * BS - 1), DW'(i)};
      n_vec++;
      if (beats[i] !== e) begin n_err++; $display("FAIL b2b_beat%0d got=%h want=%h", i, beats[i], e); end
    end
  endtask

  task automatic test_mode_change_full();
    logic [DW:0] beats[$];
    logic [DW:0] e;
    int guard;
    rstf = 1; step(); rstf = 0;
    mock = 1; cap = 1; rdy = 1; adc_v = 0;
    for (int c = 0; c < 60 && beats.size() < BS; c++) begin
      if (o_valid && rdy) beats.push_back({o_last, o_data});
      if (beats.size() == 2) mock = 0;
      adc_v = 1'($urandom_range(0, 1)); adc_d = DW'($urandom);
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL mode_cycle dut=%h model=%h", dut_view(), model_view()); end
    end
    for (int i = 0; i < BS; i++) begin
      e = {(i == BS - 1), DW'(i)};
      n_vec++;
      if (i >= beats.size() || beats[i] !== e) begin
        n_err++; $display("FAIL mode_beat%0d got=%h want=%h", i, (i < beats.size()) ? beats[i] : '0, e);
      end
    end
    adc_v = 0;
    guard = 0;
    while (!(m_mode == 1 && !m_src) && guard < 20) begin step(); guard++; end
    rdy = 0;
    while (exp_q.size() < FD && guard < 40) begin
      adc_v = 1; adc_d = DW'($urandom);
      step(); guard++;
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL full_fill dut=%h model=%h", dut_view(), model_view()); end
    end
    n_vec++;
    if (o_ovf !== 1'b0 || exp_q.size() != FD) begin n_err++; $display("FAIL full_reached got=%b/%0d want=0/%0d", o_ovf, exp_q.size(), FD); end
    rdy = 1;
    for (int i = 0; i < FD; i++) begin
      adc_v = 1; adc_d = DW'($urandom);
      step();
      n_vec++;
      if (o_ovf !== 1'b0) begin n_err++; $display("FAIL full_pushpop%0d got=%b want=0", i, o_ovf); end
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL full_cycle dut=%h model=%h", dut_view(), model_view()); end
    end
    adc_v = 0; cap = 0;
    for (int c = 0; c < 60 && !(m_mode == 0 && exp_q.size() == 0); c++) begin
      rdy = 1'($urandom_range(0, 1));
      step();
      n_vec++;
      if (dut_view() !== model_view()) begin n_err++; $display("FAIL full_drain dut=%h model=%h", dut_view(), model_view()); end
    end
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL full_end_busy got=%b want=0", o_busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n = 0;
    cap = 0; mock = 0; rstf = 0; adc_v = 0; adc_d = '0; rdy = 0;
    repeat (2) @(negedge clk);
    areset_n = 1;
    @(negedge clk);
    test_reset();
    test_nominal_mock();
    test_overflow();
    test_flush();
    test_abort();
    test_back_to_back();
    test_mode_change_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/capture_batcher.md
Name: capture_batcher

Overview:
Sample-capture stage that sits directly downstream of the register-control block. It consumes that block's capture-enable, mock-enable and reset-fifo controls, and produces the fifo-overflow and batch-ready status it reads back. It takes samples from either the ADC front end or an internal ramp generator, groups them into fixed-size batches, and buffers them in a small FIFO. The buffered samples go out over a valid/ready stream to the SDRAM writer, with the final sample of each batch tagged.

Parameters:
DATA_WIDTH, 12, sample width in bits
BATCH_SIZE, 1024, samples per batch; must be >= 2
FIFO_DEPTH, 16, internal FIFO entries; power of 2, >= 2
MOCK_DIV, 4, clock cycles per mock sample; must be >= 1

Ports:
i_clk  in  1  clock
i_areset_n  in  1  reset; asynchronous, active-low
i_capture_enable  in  1  level; capture runs while high
i_mock_enable  in  1  select ramp source instead of ADC
i_reset_fifo  in  1  synchronous flush/clear; level-sensitive
i_adc_data  in  DATA_WIDTH  ADC sample
i_adc_valid  in  1  i_adc_data valid this cycle; no backpressure to ADC
o_data  out  DATA_WIDTH  output sample
o_valid  out  1  o_data valid
o_last  out  1  o_data is sample BATCH_SIZE-1 of a complete batch
i_ready  in  1  downstream accepts when o_valid and i_ready are both high
o_fifo_overflow  out  1  sticky: a sample was dropped
o_batch_ready  out  1  a complete batch has been fully delivered downstream
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; FIFO empty; sample counter, ramp value and mock divider all 0.
- Reset outputs: o_valid, o_last, o_fifo_overflow, o_batch_ready and o_busy all 0; o_data 0.
- States: IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE when i_capture_enable is high.
  - On this transition i_mock_enable is latched into src_mock and the sample counter is cleared.
  - src_mock is held for the whole batch; changes to i_mock_enable mid-batch are ignored.
- Source sample event:
  - ADC mode: i_adc_valid high.
  - Mock mode: divider reaches MOCK_DIV-1; the divider then wraps to 0 and the event carries the current ramp value.
  - Ramp increments by 1 per event, modulo 2^DATA_WIDTH, and persists across batches.
  - Divider and ramp advance only in CAPTURE while in mock mode.
- CAPTURE, on a source event:
  - FIFO not full: push {last, data}, where last = (counter == BATCH_SIZE-1); counter increments.
  - If the pushed entry is last -> DRAIN.
  - FIFO full: sample dropped; counter unchanged; o_fifo_overflow set. The ramp still advances.
- CAPTURE with i_capture_enable low (abort): -> DRAIN, no push that cycle. The partial batch drains with no entry tagged last.
- DRAIN: no pushes.
  - When the FIFO is empty: -> CAPTURE if i_capture_enable is high (new batch: counter cleared, src_mock re-latched), else -> IDLE.
- Output side:
  - FIFO is first-word-fall-through; o_data/o_last/o_valid come straight from the FIFO head.
  - A sample pushed at edge N is visible on the outputs from cycle N+1.
  - Pop when o_valid and i_ready are both high.
  - o_valid must not depend combinationally on i_ready.
- Simultaneous push and pop on a full FIFO: legal. The push is accepted because fullness is evaluated after the pop, so no overflow.
- o_batch_ready:
  - Set on an accepted beat with o_last = 1.
  - Cleared on the first accepted beat of the next batch, or by i_reset_fifo.
  - Set has priority over clear if both occur in the same cycle.
- i_reset_fifo (synchronous, highest priority, every cycle it is high):
  - FIFO emptied; counter, divider and ramp set to 0; o_fifo_overflow and o_batch_ready cleared; state IDLE.
  - Samples arriving that cycle are discarded.
  - o_valid is 0 on the following cycle.
- Widths:
  - Counter is $clog2(BATCH_SIZE) bits wide, compared against BATCH_SIZE-1.
  - FIFO occupancy count is $clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Package capture_pkg: capture_state_e {IDLE, CAPTURE, DRAIN}; a packed struct for a FIFO entry {logic last; logic [DATA_WIDTH-1:0] data}.
- Sub-module sync_fifo: single-clock, FWFT, parameterised WIDTH/DEPTH, with full, empty and count outputs and a synchronous flush input. Instantiated here with WIDTH = DATA_WIDTH+1.

Test Plan:
1. Nominal mock batch: BATCH_SIZE=8, MOCK_DIV=1, mock on, capture on, i_ready=1 -> o_data 0..7; o_last only on 7; o_batch_ready rises the cycle after that beat; no overflow.
2. Overflow: FIFO_DEPTH=4, ADC mode, i_ready=0, 6 ADC samples 0xA0..0xA5 -> overflow set on 0xA4; after i_ready=1, outputs are 0xA0..0xA3 only and the flag stays set.
3. Flush: i_reset_fifo pulsed in CAPTURE with 3 entries buffered -> next cycle o_valid=0, o_busy=0, overflow/batch_ready=0; a new mock batch restarts the ramp at 0.
4. Abort: capture dropped after 3 of 8 samples -> exactly 3 beats, none with o_last; o_batch_ready stays 0; state ends IDLE.
5. Back-to-back batches: capture held high, BATCH_SIZE=8 -> second batch carries ramp 8..15 with o_last on 15; o_batch_ready clears on the beat carrying 8 and re-sets after 15.
6. Mid-batch mode change and full-FIFO simultaneity: mock toggled mid-batch is ignored until the next batch; push + pop on a full FIFO causes no overflow.
